led_pattern_ctrl: RTL and testbench



---
 rtl/led_pattern_ctrl_pkg.sv | 14 +
 rtl/led_pattern_ctrl_if.sv | 14 +
 rtl/led_tick_gen.sv | 29 ++
 rtl/led_pattern_ctrl.sv | 165 ++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pattern_ctrl_pkg.sv
// Shared mode codes and FSM state encoding for the LED pattern sequencer.
package led_ctrl_pkg;

    localparam logic [1:0] MODE_CHASE  = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Command channel into the LED sequencer: valid/ready plus the command fields.
interface led_pattern_ctrl_if #(
    parameter int PERIOD_W = 32,
    parameter int COUNT_W  = 8
);
    logic                valid;
    logic                ready;
    logic [1:0]          mode;
    logic [PERIOD_W-1:0] period;
    logic [COUNT_W-1:0]  count;

    modport master (output valid, output mode, output period, output count, input ready);
    modport slave  (input valid, input mode, input period, input count, output ready);
endinterface

// File: rtl/led_tick_gen.sv
// Step prescaler: fires o_tick once every i_period enabled cycles, idles at zero when disabled.
module led_tick_gen #(
    parameter int PERIOD_W = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_tick
);

    logic [PERIOD_W-1:0] count_q;
    logic                at_end;

    // i_period is never zero while enabled, so period-1 cannot underflow in use.
    assign at_end = (count_q == i_period - PERIOD_W'(1));
    assign o_tick = i_enable && at_end;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (!i_enable || at_end) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: accepts one command, animates chase/bounce/fill/blink for N passes, then blanks.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PERIOD_W = 32,
    parameter int COUNT_W  = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    led_pattern_ctrl_if.slave   cmd,
    input  logic                i_abort,
    output logic [WIDTH-1:0]    o_led,
    output logic                o_busy,
    output logic                o_done
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [COUNT_W-1:0]  pass_q, pass_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                down_q, down_d;
    logic [WIDTH-1:0]    led_d;
    logic                done_d;

    logic                tick;
    logic [WIDTH-1:0]    step_led;
    logic [IDX_W-1:0]    step_idx;
    logic                step_down;
    logic                pass_end;
    logic                last_pass;

    function automatic logic [WIDTH-1:0] onehot(input logic [IDX_W-1:0] idx);
        return WIDTH'(1) << idx;
    endfunction

    // Thermometer of idx+1 ones; the shift overflows to zero at the top so the subtract gives all-ones.
    function automatic logic [WIDTH-1:0] fill_mask(input logic [IDX_W-1:0] idx);
        return (WIDTH'(2) << idx) - WIDTH'(1);
    endfunction

    led_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (state_q == ST_RUN),
        .i_period (period_q),
        .o_tick   (tick)
    );

    assign cmd.ready = (state_q == ST_IDLE);
    assign o_busy    = (state_q == ST_RUN);
    assign last_pass = (count_q != '0) && (pass_q == count_q - COUNT_W'(1));

    // Next pattern value for the current mode, plus whether this step closes a pass.
    always_comb begin
        step_led  = o_led;
        step_idx  = idx_q;
        step_down = down_q;
        pass_end  = 1'b0;
        case (mode_q)
            MODE_CHASE: begin
                step_idx = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                step_led = onehot(step_idx);
                pass_end = (idx_q == IDX_LAST);
            end
            MODE_BOUNCE: begin
                if (down_q) begin
                    step_idx  = idx_q - IDX_W'(1);
                    step_down = (step_idx != '0);
                    pass_end  = (step_idx == '0);
                end else begin
                    step_idx  = idx_q + IDX_W'(1);
                    step_down = (step_idx == IDX_LAST);
                end
                step_led = onehot(step_idx);
            end
            MODE_FILL: begin
                step_idx = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                step_led = fill_mask(step_idx);
                pass_end = (idx_q == IDX_LAST);
            end
            default: begin
                step_led = ~o_led;
                pass_end = (o_led == '0);
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        period_d = period_q;
        count_d  = count_q;
        pass_d   = pass_q;
        idx_d    = idx_q;
        down_d   = down_q;
        led_d    = o_led;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd.valid) begin
                    state_d  = ST_RUN;
                    mode_d   = cmd.mode;
                    period_d = (cmd.period == '0) ? PERIOD_W'(1) : cmd.period;
                    count_d  = cmd.count;
                    pass_d   = '0;
                    idx_d    = '0;
                    down_d   = 1'b0;
                    led_d    = (cmd.mode == MODE_BLINK) ? '1 : WIDTH'(1);
                end
            end
            ST_RUN: begin
                // Abort takes priority over a coincident final tick, so no done pulse then.
                if (i_abort) begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                end else if (tick) begin
                    if (pass_end && last_pass) begin
                        state_d = ST_IDLE;
                        led_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        led_d  = step_led;
                        idx_d  = step_idx;
                        down_d = step_down;
                        if (pass_end && count_q != '0) begin
                            pass_d = pass_q + COUNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_CHASE;
            period_q <= '0;
            count_q  <= '0;
            pass_q   <= '0;
            idx_q    <= '0;
            down_q   <= 1'b0;
            o_led    <= '0;
            o_done   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            count_q  <= count_d;
            pass_q   <= pass_d;
            idx_q    <= idx_d;
            down_q   <= down_d;
            o_led    <= led_d;
            o_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: cycle-accurate behavioural model plus directed literal checkpoints.
module tb_led_pattern_ctrl;

    localparam int W  = 8;
    localparam int PW = 32;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         abort;
    logic [W-1:0] led;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    led_pattern_ctrl_if #(.PERIOD_W(PW), .COUNT_W(CW)) cmd_bus ();

    led_pattern_ctrl #(.WIDTH(W), .PERIOD_W(PW), .COUNT_W(CW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .cmd     (cmd_bus),
        .i_abort (abort),
        .o_led   (led),
        .o_busy  (busy),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: position s = steps since start, the pattern is a pure function of (mode, s mod pass length).
    function automatic int plen(input int md);
        case (md)
            0: return W;
            1: return 2 * (W - 1);
            2: return W;
            default: return 2;
        endcase
    endfunction

    function automatic logic [W-1:0] pat(input int md, input int i);
        logic [63:0] one;
        one = 64'd1;
        case (md)
            0: return W'(one << i);
            1: return (i < W) ? W'(one << i) : W'(one << (2 * (W - 1) - i));
            2: return W'((one << (i + 1)) - 1);
            default: return (i % 2 == 0) ? {W{1'b1}} : {W{1'b0}};
        endcase
    endfunction

    logic         m_run    = 1'b0;
    logic [W-1:0] m_led    = '0;
    logic         m_done   = 1'b0;
    int           m_mode   = 0;
    int           m_period = 1;
    int           m_count  = 0;
    longint       m_t      = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_led  <= '0;
            m_done <= 1'b0;
            m_t    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_run) begin
                if (abort) begin
                    m_run <= 1'b0;
                    m_led <= '0;
                end else if (m_count != 0 && (m_t / m_period) == longint'(m_count) * plen(m_mode)) begin
                    m_run  <= 1'b0;
                    m_led  <= '0;
                    m_done <= 1'b1;
                end else begin
                    m_led <= pat(m_mode, int'((m_t / m_period) % plen(m_mode)));
                    m_t   <= m_t + 1;
                end
            end else if (cmd_bus.valid) begin
                m_run    <= 1'b1;
                m_mode   <= int'(cmd_bus.mode);
                m_period <= (cmd_bus.period == 0) ? 1 : int'(cmd_bus.period);
                m_count  <= int'(cmd_bus.count);
                m_t      <= 1;
                m_led    <= pat(int'(cmd_bus.mode), 0);
            end
        end
    end

    always @(negedge clk) begin
        check("model_led", led, m_led);
        check("model_done", done, m_done);
        check("model_busy", busy, m_run);
        check("model_ready", cmd_bus.ready, !m_run);
    end

    task automatic issue(input logic [1:0] md, input int per, input int cnt);
        check("issue_ready", cmd_bus.ready, 1'b1);
        cmd_bus.mode   = md;
        cmd_bus.period = PW'(per);
        cmd_bus.count  = CW'(cnt);
        cmd_bus.valid  = 1'b1;
        @(negedge clk);
        cmd_bus.valid  = 1'b0;
    endtask

    logic [W-1:0] led_at [0:31];
    logic         done_at [0:31];
    int           dcyc;
    int           nrun;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        cmd_bus.valid  = 1'b0;
        cmd_bus.mode   = 2'd0;
        cmd_bus.period = '0;
        cmd_bus.count  = '0;
        abort          = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_led", led, 8'h00);
        check("rst_ready", cmd_bus.ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_led", led, 8'h00);
        check("idle_done", done, 1'b0);

        // CHASE period 3, one pass
        issue(2'd0, 3, 1);
        for (int c = 1; c <= 26; c++) begin
            led_at[c]  = led;
            done_at[c] = done;
            @(negedge clk);
        end
        check("chase_c1", led_at[1], 8'h01);
        check("chase_c3", led_at[3], 8'h01);
        check("chase_c4", led_at[4], 8'h02);
        check("chase_c22", led_at[22], 8'h80);
        check("chase_c24", led_at[24], 8'h80);
        check("chase_c24_done", done_at[24], 1'b0);
        check("chase_c25", led_at[25], 8'h00);
        check("chase_c25_done", done_at[25], 1'b1);
        check("chase_c26_done", done_at[26], 1'b0);

        // BOUNCE period 0 (runs as 1), two passes
        issue(2'd1, 0, 2);
        dcyc = 0;
        for (int c = 1; c <= 100 && dcyc == 0; c++) begin
            if (c == 8)  check("bnc_c8", led, 8'h80);
            if (c == 9)  check("bnc_c9", led, 8'h40);
            if (c == 14) check("bnc_c14", led, 8'h02);
            if (c == 15) check("bnc_c15", led, 8'h01);
            if (c == 16) check("bnc_c16", led, 8'h02);
            if (done) dcyc = c;
            else @(negedge clk);
        end
        check("bnc_done_cycle", dcyc, 29);
        check("bnc_done_led", led, 8'h00);
        @(negedge clk);

        // FILL period 2, endless until abort
        issue(2'd2, 2, 0);
        nrun = $urandom_range(20, 60);
        for (int c = 1; c <= nrun; c++) begin
            if (c == 1)  check("fill_c1", led, 8'h01);
            if (c == 3)  check("fill_c3", led, 8'h03);
            if (c == 15) check("fill_c15", led, 8'hFF);
            if (c == 17) check("fill_c17", led, 8'h01);
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("fill_abort_led", led, 8'h00);
        check("fill_abort_busy", busy, 1'b0);
        check("fill_abort_done", done, 1'b0);
        @(negedge clk);

        // Handshake: BLINK held valid during a CHASE run is taken on the done cycle
        cmd_bus.mode   = 2'd0;
        cmd_bus.period = PW'(1);
        cmd_bus.count  = CW'(1);
        cmd_bus.valid  = 1'b1;
        @(negedge clk);
        cmd_bus.mode = 2'd3;
        dcyc = 0;
        for (int c = 1; c <= 100 && dcyc == 0; c++) begin
            if (done) dcyc = c;
            else begin
                if (c == 2) check("hs_ready_in_run", cmd_bus.ready, 1'b0);
                @(negedge clk);
            end
        end
        check("hs_done_cycle", dcyc, 9);
        check("hs_done_ready", cmd_bus.ready, 1'b1);
        @(negedge clk);
        cmd_bus.valid = 1'b0;
        check("hs_blink_led", led, 8'hFF);
        check("hs_blink_busy", busy, 1'b1);
        repeat (5) @(negedge clk);

        // Abort coincident with the final tick
        issue(2'd0, 1, 1);
        repeat (7) @(negedge clk);
        check("col_last_led", led, 8'h80);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("col_done", done, 1'b0);
        check("col_led", led, 8'h00);
        @(negedge clk);

        // Asynchronous reset in RUN
        issue(2'd1, 2, 0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("runrst_led", led, 8'h00);
        check("runrst_busy", busy, 1'b0);
        check("runrst_ready", cmd_bus.ready, 1'b1);
        check("runrst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cmd_bus.valid  = ($urandom_range(0, 3) == 0);
            cmd_bus.mode   = 2'($urandom_range(0, 3));
            cmd_bus.period = PW'($urandom_range(0, 3));
            cmd_bus.count  = CW'($urandom_range(0, 3));
            abort          = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        cmd_bus.valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("end_idle_ready", cmd_bus.ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
